// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the two requester ports and the single-port memory
//               word ports that mem_arbiter sits between.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int c_AW = $clog2(DEPTH);

    // Requester port 0 (instruction fetch)
    logic             p0_req_i;
    logic             p0_we_i;
    logic [c_AW-1:0]  p0_addr_i;
    logic [WIDTH-1:0] p0_wdata_i;
    logic             p0_gnt_o;
    logic             p0_rvalid_o;
    logic [WIDTH-1:0] p0_rdata_o;

    // Requester port 1 (load/store)
    logic             p1_req_i;
    logic             p1_we_i;
    logic [c_AW-1:0]  p1_addr_i;
    logic [WIDTH-1:0] p1_wdata_i;
    logic             p1_gnt_o;
    logic             p1_rvalid_o;
    logic [WIDTH-1:0] p1_rdata_o;

    // Memory word ports
    logic             read_word_en_o;
    logic [c_AW-1:0]  read_word_pos_o;
    logic [WIDTH-1:0] read_word_data_i;
    logic             write_word_en_o;
    logic [c_AW-1:0]  write_word_pos_o;
    logic [WIDTH-1:0] write_word_data_o;

    // Arbiter side
    modport slave (
        input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        input  read_word_data_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output read_word_en_o, read_word_pos_o,
        output write_word_en_o, write_word_pos_o, write_word_data_o
    );

    // Requester/memory side
    modport master (
        output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        output read_word_data_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  read_word_en_o, read_word_pos_o,
        input  write_word_en_o, write_word_pos_o, write_word_data_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-port word
//               memory. Grants one access per cycle combinationally and
//               steers the registered read data back to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_arbiter_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH);

    logic             r_last;      // port granted most recently
    logic             r_rd_pend;   // a read was granted last cycle
    logic             r_rd_owner;  // port owning that read

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any;
    logic             w_win_we;
    logic [c_AW-1:0]  w_win_addr;
    logic [WIDTH-1:0] w_win_wdata;
    logic             w_rd_gnt;
    logic             w_wr_gnt;
    logic             w_rv0;
    logic             w_rv1;

    // Round-robin pick: on a tie the port that did not win last time goes.
    // Everything is held off while reset is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_ni) begin
            if (bus.p0_req_i && bus.p1_req_i) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = bus.p0_req_i;
                w_gnt1 = bus.p1_req_i;
            end
        end
    end

    // Select the winning port's command
    always_comb begin
        w_any       = w_gnt0 | w_gnt1;
        w_win_we    = w_gnt1 ? bus.p1_we_i    : bus.p0_we_i;
        w_win_addr  = w_gnt1 ? bus.p1_addr_i  : bus.p0_addr_i;
        w_win_wdata = w_gnt1 ? bus.p1_wdata_i : bus.p0_wdata_i;
        w_rd_gnt    = w_any && !w_win_we;
        w_wr_gnt    = w_any &&  w_win_we;
    end

    assign bus.p0_gnt_o = w_gnt0;
    assign bus.p1_gnt_o = w_gnt1;

    // Memory drive; idle ports are forced to zero so the bus is quiet
    assign bus.read_word_en_o    = w_rd_gnt;
    assign bus.read_word_pos_o   = w_rd_gnt ? w_win_addr  : '0;
    assign bus.write_word_en_o   = w_wr_gnt;
    assign bus.write_word_pos_o  = w_wr_gnt ? w_win_addr  : '0;
    assign bus.write_word_data_o = w_wr_gnt ? w_win_wdata : '0;

    // Arbitration history and outstanding-read tracking
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last     <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (w_any) begin
                r_last <= w_gnt1;
            end
            r_rd_pend <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_owner <= w_gnt1;
            end
        end
    end

    // Response steering; gated by reset so a read in flight when reset
    // arrives never shows up as a valid response
    always_comb begin
        w_rv0 = rst_ni && r_rd_pend && !r_rd_owner;
        w_rv1 = rst_ni && r_rd_pend &&  r_rd_owner;
    end

    assign bus.p0_rvalid_o = w_rv0;
    assign bus.p1_rvalid_o = w_rv1;
    assign bus.p0_rdata_o  = w_rv0 ? bus.read_word_data_i : '0;
    assign bus.p1_rdata_o  = w_rv1 ? bus.read_word_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a behavioural word
//               memory, a reference arbitration model and a read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int c_WIDTH = 32;
    localparam int c_DEPTH = 16;
    localparam int c_AW    = 4;

    typedef struct packed {
        logic              rn;
        logic              r0;
        logic              w0;
        logic [c_AW-1:0]   a0;
        logic [c_WIDTH-1:0] d0;
        logic              r1;
        logic              w1;
        logic [c_AW-1:0]   a1;
        logic [c_WIDTH-1:0] d1;
    } stim_t;

    typedef struct {
        bit                 port;
        logic [c_WIDTH-1:0] data;
        int                 cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;

    mem_arbiter_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) bus ();

    mem_arbiter #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with one cycle read latency
    logic [c_WIDTH-1:0] phys [c_DEPTH];
    always @(posedge clk) begin
        if (bus.write_word_en_o) phys[bus.write_word_pos_o] <= bus.write_word_data_o;
        if (bus.read_word_en_o)  bus.read_word_data_i <= phys[bus.read_word_pos_o];
    end

    // Reference model state
    bit                 m_last = 1'b1;
    logic [c_WIDTH-1:0] m_mem [c_DEPTH];
    rsp_t               sb [$];
    int                 cyc   = 0;
    int                 total = 0;
    int                 bad   = 0;

    // Expected values for the current cycle and what the model commits at the edge
    logic [5:0]                     e_ctl;
    logic [2*c_AW+3*c_WIDTH-1:0]    e_dat;
    logic                           p_g0, p_g1, p_ren, p_wen;
    logic [c_AW-1:0]                p_addr;
    logic [c_WIDTH-1:0]             p_wd;

    wire [5:0] o_ctl = {bus.p0_gnt_o, bus.p1_gnt_o, bus.read_word_en_o,
                        bus.write_word_en_o, bus.p0_rvalid_o, bus.p1_rvalid_o};
    wire [2*c_AW+3*c_WIDTH-1:0] o_dat = {bus.read_word_pos_o, bus.write_word_pos_o,
                        bus.write_word_data_o, bus.p0_rdata_o, bus.p1_rdata_o};

    function automatic stim_t mk(input bit rn, input bit r0, input bit w0, input int a0,
                                 input logic [31:0] d0, input bit r1, input bit w1,
                                 input int a1, input logic [31:0] d1);
        stim_t s;
        s.rn = rn; s.r0 = r0; s.w0 = w0; s.a0 = a0[c_AW-1:0]; s.d0 = d0;
        s.r1 = r1; s.w1 = w1; s.a1 = a1[c_AW-1:0]; s.d1 = d1;
        return s;
    endfunction

    // Drive one cycle of stimulus and compute the expected outputs at mid-cycle
    task automatic apply(input stim_t s);
        rsp_t r;
        logic we;
        logic rv0, rv1;
        logic [c_WIDTH-1:0] rd0, rd1;
        rst_n = s.rn;
        bus.p0_req_i = s.r0; bus.p0_we_i = s.w0; bus.p0_addr_i = s.a0; bus.p0_wdata_i = s.d0;
        bus.p1_req_i = s.r1; bus.p1_we_i = s.w1; bus.p1_addr_i = s.a1; bus.p1_wdata_i = s.d1;
        @(negedge clk);
        p_g0 = 1'b0;
        p_g1 = 1'b0;
        if (s.rn) begin
            if (s.r0 && s.r1) begin
                p_g0 = (m_last == 1'b1);
                p_g1 = (m_last == 1'b0);
            end else begin
                p_g0 = s.r0;
                p_g1 = s.r1;
            end
        end
        we     = p_g1 ? s.w1 : s.w0;
        p_addr = p_g1 ? s.a1 : s.a0;
        p_wd   = p_g1 ? s.d1 : s.d0;
        p_ren  = (p_g0 || p_g1) && !we;
        p_wen  = (p_g0 || p_g1) &&  we;
        rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            r = sb.pop_front();
            if (s.rn) begin
                if (r.port) begin rv1 = 1'b1; rd1 = r.data; end
                else        begin rv0 = 1'b1; rd0 = r.data; end
            end
        end
        e_ctl = {p_g0, p_g1, p_ren, p_wen, rv0, rv1};
        e_dat = {(p_ren ? p_addr : 4'd0), (p_wen ? p_addr : 4'd0),
                 (p_wen ? p_wd : 32'd0), rd0, rd1};
    endtask

    // Clock edge: update the model the same way the memory system should
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            m_last = 1'b1;
            sb.delete();
        end else begin
            if (p_g0 || p_g1) m_last = p_g1;
            if (p_wen) m_mem[p_addr] = p_wd;
            if (p_ren) sb.push_back('{p_g1, m_mem[p_addr], cyc});
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        stim_t rows [$];
        rows.push_back(mk(0, 1, 1, 1, 32'h11, 1, 1, 2, 32'h22));
        rows.push_back(mk(0, 1, 1, 1, 32'h11, 1, 1, 2, 32'h22));
        rows.push_back(mk(1, 1, 1, 1, 32'h11, 1, 1, 2, 32'h22));
        rows.push_back(mk(1, 0, 0, 0, 0,      1, 1, 2, 32'h22));
        rows.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            total++;
            if (o_ctl !== e_ctl) begin
                bad++;
                $display("FAIL reset_ctl row=%0d got=%b want=%b", i, o_ctl, e_ctl);
            end
            total++;
            if (o_dat !== e_dat) begin
                bad++;
                $display("FAIL reset_dat row=%0d got=%h want=%h", i, o_dat, e_dat);
            end
            advance();
        end
    endtask

    task automatic test_write_read();
        stim_t rows [$];
        rows.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 32'd69));
        rows.push_back(mk(1, 0, 0, 0, 0, 1, 0, 5, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            total++;
            if (o_ctl !== e_ctl) begin
                bad++;
                $display("FAIL write_read_ctl row=%0d got=%b want=%b", i, o_ctl, e_ctl);
            end
            total++;
            if (o_dat !== e_dat) begin
                bad++;
                $display("FAIL write_read_dat row=%0d got=%h want=%h", i, o_dat, e_dat);
            end
            advance();
        end
    endtask

    task automatic test_contention();
        stim_t rows [$];
        for (int k = 0; k < 6; k++) rows.push_back(mk(1, 1, 0, 1, 0, 1, 0, 2, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            total++;
            if (o_ctl !== e_ctl) begin
                bad++;
                $display("FAIL contention_ctl row=%0d got=%b want=%b", i, o_ctl, e_ctl);
            end
            total++;
            if (o_dat !== e_dat) begin
                bad++;
                $display("FAIL contention_dat row=%0d got=%h want=%h", i, o_dat, e_dat);
            end
            advance();
        end
    endtask

    task automatic test_raw();
        stim_t rows [$];
        rows.push_back(mk(1, 1, 1, 3, 32'hA5, 0, 0, 0, 0));
        rows.push_back(mk(1, 0, 0, 0, 0,      1, 0, 3, 0));
        rows.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            total++;
            if (o_ctl !== e_ctl) begin
                bad++;
                $display("FAIL raw_ctl row=%0d got=%b want=%b", i, o_ctl, e_ctl);
            end
            total++;
            if (o_dat !== e_dat) begin
                bad++;
                $display("FAIL raw_dat row=%0d got=%h want=%h", i, o_dat, e_dat);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_read();
        stim_t rows [$];
        rows.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 0, 1, 0, 2, 0));
        rows.push_back(mk(1, 1, 0, 1, 0, 1, 0, 2, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            total++;
            if (o_ctl !== e_ctl) begin
                bad++;
                $display("FAIL reset_mid_read_ctl row=%0d got=%b want=%b", i, o_ctl, e_ctl);
            end
            total++;
            if (o_dat !== e_dat) begin
                bad++;
                $display("FAIL reset_mid_read_dat row=%0d got=%h want=%h", i, o_dat, e_dat);
            end
            advance();
        end
    endtask

    task automatic test_idle_gap();
        stim_t rows [$];
        rows.push_back(mk(1, 0, 0, 0, 0, 1, 0, 5, 0));
        for (int k = 0; k < 3; k++) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 3, 0, 1, 0, 1, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            total++;
            if (o_ctl !== e_ctl) begin
                bad++;
                $display("FAIL idle_gap_ctl row=%0d got=%b want=%b", i, o_ctl, e_ctl);
            end
            total++;
            if (o_dat !== e_dat) begin
                bad++;
                $display("FAIL idle_gap_dat row=%0d got=%h want=%h", i, o_dat, e_dat);
            end
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.p0_req_i = 1'b0; bus.p0_we_i = 1'b0; bus.p0_addr_i = '0; bus.p0_wdata_i = '0;
        bus.p1_req_i = 1'b0; bus.p1_we_i = 1'b0; bus.p1_addr_i = '0; bus.p1_wdata_i = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_contention();
        test_raw();
        test_reset_mid_read();
        test_idle_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single-port word `memory` (one read or one write per cycle) between the instruction-fetch requester (port 0) and the load/store requester (port 1). Grants at most one request per cycle and drives the memory's read/write word ports from the winner. Steers the registered read data back to the granted port one cycle later. Sits between the core's fetch/LSU stages and the `memory` instance.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits
- `DEPTH`, 16, memory depth in words; address width `AW = $clog2(DEPTH)`

Ports:
- `clk_i` in 1: clock, all state updates on rising edge
- `rst_ni` in 1: reset, synchronous, active-low
- `p0_req_i` / `p1_req_i` in 1: request valid, held until granted
- `p0_we_i` / `p1_we_i` in 1: 1 = write, 0 = read
- `p0_addr_i` / `p1_addr_i` in AW: word address
- `p0_wdata_i` / `p1_wdata_i` in WIDTH: write data
- `p0_gnt_o` / `p1_gnt_o` out 1: request accepted this cycle (combinational)
- `p0_rvalid_o` / `p1_rvalid_o` out 1: read data valid, one cycle after a read grant
- `p0_rdata_o` / `p1_rdata_o` out WIDTH: read data; 0 when matching rvalid is low
- `read_word_en_o` out 1: memory read enable
- `read_word_pos_o` out AW: memory read address
- `read_word_data_i` in WIDTH: memory read data, valid cycle after `read_word_en_o`
- `write_word_en_o` out 1: memory write enable
- `write_word_pos_o` out AW: memory write address
- `write_word_data_o` out WIDTH: memory write data

## Operation
- State: `last_q` (1 bit, port granted most recently), `rd_pend_q` (1 bit, a read was granted last cycle), `rd_owner_q` (1 bit, port owning that read).
- Arbitration, combinational, every cycle with `rst_ni`=1:
  - only one req high -> grant it
  - both high -> grant port != `last_q` (round-robin)
  - none -> no grant; `last_q` holds
- On grant: `last_q` <= granted port.
- Memory drive from winner: read -> `read_word_en_o`=1, `read_word_pos_o`=addr; write -> `write_word_en_o`=1, `write_word_pos_o`=addr, `write_word_data_o`=wdata. Never both enables in one cycle. With no grant, enables 0, pos/data 0.
- Read grant: `rd_pend_q` <= 1, `rd_owner_q` <= port; otherwise `rd_pend_q` <= 0.
- Response: `pX_rvalid_o` = `rd_pend_q` && `rd_owner_q`==X; `pX_rdata_o` = `read_word_data_i` when that rvalid is high, else 0.
- Writes produce no rvalid; write complete at grant edge.
- Requester drops or changes req only after gnt; arbiter does not check this.

## Timing
- Reset (`rst_ni`=0 at rising edge): `last_q`=1 (port 0 wins first tie), `rd_pend_q`=0, `rd_owner_q`=0. While `rst_ni`=0, all gnt, rvalid, enables = 0, rdata/pos/data = 0, regardless of req.
- Grant latency 0 cycles (gnt same cycle as req if winning); read data latency 1 cycle after grant.
- Throughput: one access per cycle; back-to-back reads from either/alternating ports fully pipelined (response N overlaps grant N+1).
- Both requesting continuously -> strict alternation 0,1,0,1...; max wait for a held request = 1 cycle.
- Write at cycle N, read same address granted at N+1 -> returns new data at N+2.
- Reset asserted while `rd_pend_q`=1 -> pending response dropped, no rvalid next cycle.
- Requester deasserts without grant -> no side effect, `last_q` unchanged.

## Test plan
- Reset: hold `rst_ni`=0 2 cycles with both reqs high -> all gnt/enables/rvalid 0; release -> port 0 granted first.
- Single write then read: p1 write addr 5 data 69 -> `p1_gnt_o`=1, `write_word_en_o`=1 pos 5 data 69; next cycle p1 read addr 5 -> `p1_rvalid_o`=1, `p1_rdata_o`=69 one cycle later, `p0_rvalid_o`=0.
- Contention: both read continuously (p0 addr 1 = 0x11, p1 addr 2 = 0x22) for 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid alternates one cycle behind with correct data.
- Read-after-write: p0 write addr 3 = 0xA5 at N, p1 read addr 3 granted N+1 -> `p1_rdata_o`=0xA5 at N+2.
- Reset mid-read: p0 read grant at N, `rst_ni`=0 at N+1 -> `p0_rvalid_o`=0 at N+1 and after; post-reset tie grants port 0.
- Idle gap: p1 granted, no reqs 3 cycles, then both request -> port 0 granted (last_q held at 1).
